mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates an instruction-fetch port and a data
// port onto a single 8-bit RAM, moving one byte per cycle, little-endian.
module mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [31:0]           if_data,
  input  logic                  mem_req,
  input  logic                  mem_rw,
  input  logic [1:0]            mem_size,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  output logic                  ram_rw,
  output logic [7:0]            ram_write,
  input  logic [7:0]            ram_read,
  output logic [ADDR_WIDTH-1:0] ram_addr
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned K_W    = 2;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state, state_nx;
  logic [K_W-1:0]        k, k_nx;
  logic [K_W-1:0]        last, last_nx;
  logic                  own_mem, own_mem_nx;
  logic                  rw, rw_nx;
  logic [ADDR_WIDTH-1:0] base, base_nx;
  logic [DATA_W-1:0]     wdata, wdata_nx;
  logic [DATA_W-1:0]     result, result_nx;

  logic                  if_ready_nx, mem_ready_nx, ram_rw_nx;
  logic [DATA_W-1:0]     if_data_nx, mem_rdata_nx;
  logic [BYTE_W-1:0]     ram_write_nx;
  logic [ADDR_WIDTH-1:0] ram_addr_nx;

  // State and registered outputs; RAM outputs are staged one edge ahead of use.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      k         <= '0;
      last      <= '0;
      own_mem   <= 1'b0;
      rw        <= 1'b0;
      base      <= '0;
      wdata     <= '0;
      result    <= '0;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      if_data   <= '0;
      mem_rdata <= '0;
      ram_rw    <= 1'b0;
      ram_write <= '0;
      ram_addr  <= '0;
    end else begin
      state     <= state_nx;
      k         <= k_nx;
      last      <= last_nx;
      own_mem   <= own_mem_nx;
      rw        <= rw_nx;
      base      <= base_nx;
      wdata     <= wdata_nx;
      result    <= result_nx;
      if_ready  <= if_ready_nx;
      mem_ready <= mem_ready_nx;
      if_data   <= if_data_nx;
      mem_rdata <= mem_rdata_nx;
      ram_rw    <= ram_rw_nx;
      ram_write <= ram_write_nx;
      ram_addr  <= ram_addr_nx;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx     = state;
    k_nx         = k;
    last_nx      = last;
    own_mem_nx   = own_mem;
    rw_nx        = rw;
    base_nx      = base;
    wdata_nx     = wdata;
    result_nx    = result;
    if_data_nx   = if_data;
    mem_rdata_nx = mem_rdata;
    if_ready_nx  = 1'b0;
    mem_ready_nx = 1'b0;
    ram_rw_nx    = 1'b0;
    ram_write_nx = '0;
    ram_addr_nx  = '0;

    unique case (state)
      IDLE: begin
        // Data port wins when both request in the same cycle.
        if (mem_req) begin
          own_mem_nx = 1'b1;
          base_nx    = mem_addr;
          rw_nx      = mem_rw;
          wdata_nx   = mem_wdata;
          case (mem_size)
            2'd0:    last_nx = K_W'(0);
            2'd1:    last_nx = K_W'(1);
            default: last_nx = K_W'(3);
          endcase
        end else if (if_req) begin
          own_mem_nx = 1'b0;
          base_nx    = if_addr;
          rw_nx      = 1'b0;
          wdata_nx   = '0;
          last_nx    = K_W'(3);
        end
        if (mem_req || if_req) begin
          state_nx     = BUSY;
          k_nx         = '0;
          result_nx    = '0;
          ram_addr_nx  = base_nx;
          ram_rw_nx    = rw_nx;
          ram_write_nx = rw_nx ? wdata_nx[BYTE_W-1:0] : '0;
        end
      end

      BUSY: begin
        k_nx = k + K_W'(1);
        if (!rw) result_nx[{k, 3'b000} +: BYTE_W] = ram_read;
        if (k == last) begin
          state_nx = DONE;
          if (own_mem) begin
            mem_ready_nx = 1'b1;
            if (!rw) mem_rdata_nx = result_nx;
          end else begin
            if_ready_nx = 1'b1;
            if_data_nx  = result_nx;
          end
        end else begin
          ram_addr_nx  = base + ADDR_WIDTH'(k_nx);
          ram_rw_nx    = rw;
          ram_write_nx = rw ? wdata[{k_nx, 3'b000} +: BYTE_W] : '0;
        end
      end

      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule
